// File: rtl/core_hazard_ctrl.sv
// core_hazard_ctrl
//   Hazard and sequencing controller for the 5-stage RV32I pipeline.
//   Detects load-use hazards, produces stall/bubble/flush controls,
//   registers ALU operand-forwarding selects, arbitrates PC redirects
//   (EX branch/JALR over ID JAL), freezes the pipe while the data-memory
//   port is busy and counts stall cycles (saturating).
// Ports:
//   i_clk, i_rst_n               clock, asynchronous active-low reset
//   i_id_*                       ID-stage sources, use bits, JAL and target
//   i_ex_*                       EX-stage valid/wen/load/rd, taken flag, target
//   i_mem_*                      MEM-stage valid/wen/rd
//   i_dmem_req, i_dmem_ack       data-memory access outstanding / completion
//   o_stall_if/id/ex             hold PC, IF-ID, ID-EX and EX-MEM registers
//   o_bubble_ex, o_flush_id      load NOP into ID-EX / IF-ID on the next edge
//   o_fwd_a, o_fwd_b             00 regfile, 01 MEM result, 10 WB result
//   o_redirect, o_redirect_pc    PC redirect request and target
//   o_stall_cnt                  saturating count of cycles with o_stall_if=1
module core_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_id_valid,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic             i_id_jal,
  input  logic [31:0]      i_id_jal_target,
  input  logic             i_ex_valid,
  input  logic             i_ex_wen,
  input  logic             i_ex_is_load,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_branch_jalr,
  input  logic [31:0]      i_ex_target,
  input  logic             i_mem_valid,
  input  logic             i_mem_wen,
  input  logic [4:0]       i_mem_rd,
  input  logic             i_dmem_req,
  input  logic             i_dmem_ack,
  output logic             o_stall_if,
  output logic             o_stall_id,
  output logic             o_stall_ex,
  output logic             o_bubble_ex,
  output logic             o_flush_id,
  output logic [1:0]       o_fwd_a,
  output logic [1:0]       o_fwd_b,
  output logic             o_redirect,
  output logic [31:0]      o_redirect_pc,
  output logic [CNT_W-1:0] o_stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_MEMWAIT = 2'd3
  } state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

  state_t           state_q, state_d;
  state_t           saved_q, saved_d;
  state_t           eval_state;
  logic [2:0]       flush_cnt_q, flush_cnt_d;
  logic [1:0]       fwd_a_q, fwd_a_d;
  logic [1:0]       fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic ex_wr_ok, mem_wr_ok;
  logic ex_m1, ex_m2, mem_m1, mem_m2;
  logic mem_wait, ex_redirect, load_use, id_jal;
  logic [1:0] sel_a, sel_b;

  // Stage producers are only eligible when valid, writing, and not x0.
  assign ex_wr_ok  = i_ex_valid  & i_ex_wen  & (i_ex_rd  != 5'd0);
  assign mem_wr_ok = i_mem_valid & i_mem_wen & (i_mem_rd != 5'd0);

  assign ex_m1  = i_id_use_rs1 & ex_wr_ok  & (i_ex_rd  == i_id_rs1);
  assign ex_m2  = i_id_use_rs2 & ex_wr_ok  & (i_ex_rd  == i_id_rs2);
  assign mem_m1 = i_id_use_rs1 & mem_wr_ok & (i_mem_rd == i_id_rs1);
  assign mem_m2 = i_id_use_rs2 & mem_wr_ok & (i_mem_rd == i_id_rs2);

  // A matching EX producer will be in MEM when the consumer reaches EX (01);
  // a matching MEM producer will be in WB (10). EX is the younger value.
  assign sel_a = (ex_m1 & ~i_ex_is_load) ? 2'b01 : (mem_m1 ? 2'b10 : 2'b00);
  assign sel_b = (ex_m2 & ~i_ex_is_load) ? 2'b01 : (mem_m2 ? 2'b10 : 2'b00);

  assign mem_wait    = i_dmem_req & ~i_dmem_ack;
  assign ex_redirect = i_ex_valid & i_ex_branch_jalr;
  assign load_use    = i_ex_is_load & (ex_m1 | ex_m2);
  assign id_jal      = i_id_valid & i_id_jal;

  // On the ack cycle the frozen state is resumed and evaluated in-cycle.
  assign eval_state = (state_q == ST_MEMWAIT) ? saved_q : state_q;

  always_comb begin
    o_stall_if    = 1'b0;
    o_stall_id    = 1'b0;
    o_stall_ex    = 1'b0;
    o_bubble_ex   = 1'b0;
    o_flush_id    = 1'b0;
    o_redirect    = 1'b0;
    o_redirect_pc = 32'd0;
    state_d       = state_q;
    saved_d       = saved_q;
    flush_cnt_d   = flush_cnt_q;
    fwd_a_d       = fwd_a_q;
    fwd_b_d       = fwd_b_q;

    // Outputs are forced idle while reset is held so the pipe sees no
    // controls even with non-idle inputs.
    if (i_rst_n) begin
      if (mem_wait) begin
        o_stall_if = 1'b1;
        o_stall_id = 1'b1;
        o_stall_ex = 1'b1;
        state_d    = ST_MEMWAIT;
        saved_d    = eval_state;
      end else begin
        if (ex_redirect) begin
          o_redirect    = 1'b1;
          o_redirect_pc = i_ex_target;
          o_flush_id    = 1'b1;
          o_bubble_ex   = 1'b1;
          flush_cnt_d   = FLUSH_INIT;
          state_d       = (FLUSH_CYCLES > 0) ? ST_FLUSH : ST_RUN;
        end else if (load_use) begin
          o_stall_if  = 1'b1;
          o_stall_id  = 1'b1;
          o_bubble_ex = 1'b1;
          state_d     = ST_LDSTALL;
        end else if (id_jal && eval_state != ST_FLUSH) begin
          // LDSTALL behaves as RUN here: EX holds a bubble and ID is live.
          o_redirect    = 1'b1;
          o_redirect_pc = i_id_jal_target;
          o_flush_id    = 1'b1;
          flush_cnt_d   = FLUSH_INIT;
          state_d       = (FLUSH_CYCLES > 0) ? ST_FLUSH : ST_RUN;
        end else if (eval_state == ST_FLUSH) begin
          o_flush_id  = 1'b1;
          flush_cnt_d = flush_cnt_q - 3'd1;
          state_d     = (flush_cnt_q <= 3'd1) ? ST_RUN : ST_FLUSH;
        end else begin
          state_d = ST_RUN;
        end

        if (o_bubble_ex || o_flush_id) begin
          fwd_a_d = 2'b00;
          fwd_b_d = 2'b00;
        end else begin
          fwd_a_d = sel_a;
          fwd_b_d = sel_b;
        end
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (o_stall_if && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_RUN;
      saved_q     <= ST_RUN;
      flush_cnt_q <= 3'd0;
      fwd_a_q     <= 2'b00;
      fwd_b_q     <= 2'b00;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      saved_q     <= saved_d;
      flush_cnt_q <= flush_cnt_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_fwd_a     = fwd_a_q;
  assign o_fwd_b     = fwd_b_q;
  assign o_stall_cnt = stall_cnt_q;

endmodule

// File: doc/core_hazard_ctrl.md
Name: core_hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB) around the EX-stage ALU.
- Detects load-use hazards and generates stall, bubble and flush controls.
- Produces registered operand-forwarding selects for the ALU inputs and arbitrates PC redirects between the EX-stage branch/JALR decision and the ID-stage JAL.
- Freezes the pipeline while the data-memory port is busy and counts stall cycles for performance monitoring.

Parameters:
FLUSH_CYCLES, 1, extra cycles after a redirect during which fetched instructions are discarded (0..7)
CNT_W, 32, stall-cycle counter width

Ports:
i_clk  input  1  core clock
i_rst_n  input  1  asynchronous active-low reset
i_id_valid  input  1  ID holds a valid instruction
i_id_rs1, i_id_rs2  input  5  ID source registers
i_id_use_rs1, i_id_use_rs2  input  1  ID instruction reads rs1/rs2
i_id_jal  input  1  ID instruction is JAL
i_id_jal_target  input  32  JAL target PC
i_ex_valid, i_ex_wen, i_ex_is_load  input  1  EX valid, writes rd, is a load
i_ex_rd  input  5  EX destination
i_ex_branch_jalr  input  1  ALU taken-branch/JALR flag
i_ex_target  input  32  ALU branch/JALR target
i_mem_valid, i_mem_wen  input  1  MEM valid, writes rd
i_mem_rd  input  5  MEM destination
i_dmem_req  input  1  MEM-stage access outstanding
i_dmem_ack  input  1  data memory completes access
o_stall_if, o_stall_id, o_stall_ex  output  1  hold PC / IF-ID / ID-EX,EX-MEM registers
o_bubble_ex  output  1  ID-EX loads NOP next edge
o_flush_id  output  1  IF-ID loads NOP next edge
o_fwd_a, o_fwd_b  output  2  ALU operand select for the instruction now in EX: 00 regfile, 01 MEM result, 10 WB result
o_redirect  output  1  load o_redirect_pc into PC next edge
o_redirect_pc  output  32  redirect target
o_stall_cnt  output  CNT_W  cycles with o_stall_if=1, saturating

Behaviour:
- Reset (async, i_rst_n=0): state RUN, flush counter 0, o_fwd_a/b=00, o_stall_cnt=0. All combinational outputs evaluate to 0 in RUN with idle inputs.
- States: RUN, LDSTALL, FLUSH, MEMWAIT. A save register records the state to resume after MEMWAIT.
- Match rule: a source matches a stage only when that stage is valid, its wen=1, its rd≠0 and rd equals the source, and the corresponding use bit is 1. x0 never matches.

Priority each cycle (highest first):
- MEM wait (i_dmem_req & ~i_dmem_ack):
  - Assert o_stall_if, o_stall_id and o_stall_ex.
  - Assert no redirect, bubble or flush.
  - Hold the fwd registers and the flush counter.
  - Enter MEMWAIT and save the current state (when already in MEMWAIT, keep the saved state).
  - On the ack cycle, outputs are those of the saved state evaluated normally, in the same cycle.
- EX redirect (i_ex_valid & i_ex_branch_jalr):
  - Assert o_redirect with o_redirect_pc=i_ex_target, plus o_flush_id and o_bubble_ex.
  - Any ID JAL is ignored.
  - If FLUSH_CYCLES>0, go to FLUSH with counter=FLUSH_CYCLES; otherwise stay in RUN.
- Load-use (i_ex_is_load and either ID source matches EX):
  - Assert o_stall_if, o_stall_id and o_bubble_ex for exactly one cycle; enter LDSTALL.
  - LDSTALL returns to RUN on the next cycle. The hazard cannot re-fire because EX now holds a bubble.
- ID JAL (i_id_valid & i_id_jal, RUN state, no stall):
  - Assert o_redirect with o_redirect_pc=i_id_jal_target and o_flush_id.
  - Enter FLUSH as for an EX redirect.
- FLUSH:
  - Assert o_flush_id each cycle, decrementing the counter; return to RUN when the counter reaches 1.
  - i_id_jal is ignored in this state.

Forwarding (registered, visible the cycle the instruction is in EX):
- On an edge where ID advances (no stall_id, no bubble, no MEM wait), register o_fwd_x = 01 if the source matches EX (non-load), else 10 if it matches MEM, else 00. EX takes precedence over MEM.
- After a LDSTALL, the load sits in MEM, so the re-evaluated select is 10.
- On a bubble or flush edge, the registers load 00.
- During MEM wait they hold.
- WB-stage writes are covered by the write-first regfile; no select is needed.

Other rules:
- o_redirect_pc=0 when o_redirect=0.
- o_stall_cnt increments on every cycle with o_stall_if=1 and saturates at all-ones.
- Reset asserted mid-FLUSH or mid-MEMWAIT returns to RUN immediately.

Test Plan:
- Reset, then EX=ADD x5, ID=ADD x6,x5,x1 -> next cycle o_fwd_a=01, o_fwd_b=00, no stall, o_stall_cnt=0.
- EX=LW x7, ID uses x7 as rs2 -> one cycle with o_stall_if/o_stall_id/o_bubble_ex=1; next edge o_fwd_b=10; o_stall_cnt=1.
- EX=LW x0, ID uses x0 -> no stall, o_fwd=00.
- EX taken BEQ with target 0x100 while ID holds JAL to 0x200 -> o_redirect=1 with pc 0x100, o_flush_id=1, o_bubble_ex=1; with FLUSH_CYCLES=1, o_flush_id=1 for one further cycle.
- i_dmem_req=1 and ack delayed 3 cycles while EX holds a taken branch -> 3 cycles of full stall with no redirect; on the ack cycle redirect fires; o_stall_cnt+=3.
- Assert i_rst_n=0 during FLUSH -> all outputs 0 immediately; state RUN after release.
